// File: rtl/wire_serial_rx.sv
// rtl/wire_serial_rx.sv - single-wire serial frame receiver with one-entry valid/ready output buffer
// Purpose: synchronizes the asynchronous line 'in', detects start bits, samples
//   DATA_W data bits LSB first at mid-bit, checks the stop bit and hands each
//   good word to a one-entry output buffer.
// Optional feature macro: WIRE_SERIAL_RX_PARITY_EN adds one even-parity bit
//   between the last data bit and the stop bit.
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in         raw serial line, asynchronous, idle high
//   out_data   received word, stable while out_valid=1
//   out_valid  word available
//   out_ready  consumer accepts word when out_valid && out_ready
//   frame_err  one-cycle pulse: stop bit sampled 0
//   overrun    one-cycle pulse: word completed while buffer full and not draining
//   parity_err one-cycle pulse: parity mismatch (always 0 without parity)
module wire_serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              sync1;
  logic              line_s;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W:0]   shreg_in;
  logic              par_bad;
  logic              tick;
  logic              word_ok;
  logic              stop_bad;
  logic              par_fail;
  logic              load;
  logic              drop;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      line_s <= 1'b1;
    end else begin
      sync1  <= in;
      line_s <= sync1;
    end
  end

  assign tick = (cnt == '0);

  // New bit enters at the top; after DATA_W shifts the first bit sits at bit 0.
  assign shreg_in = {line_s, shreg};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!line_s) state_nxt = START;
      START:  if (tick) state_nxt = line_s ? IDLE : DATA;
      DATA: begin
        if (tick && idx == LAST_IDX) begin
`ifdef WIRE_SERIAL_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: if (tick) state_nxt = STOP;
      STOP:   if (tick) state_nxt = line_s ? IDLE : BREAK;
      BREAK:  if (line_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: stop-bit evaluation strobes
  always_comb begin
    word_ok  = 1'b0;
    stop_bad = 1'b0;
    par_fail = 1'b0;
    if (state == STOP && tick) begin
      word_ok  = line_s && !par_bad;
      stop_bad = !line_s;
      par_fail = par_bad;
    end
  end

  // Bit-phase counter, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE:  if (!line_s) cnt <= HALF_BIT;
        BREAK: cnt <= '0;
        default: cnt <= tick ? FULL_BIT : cnt - CNT_W'(1);
      endcase
      if (state == START && tick) idx <= '0;
      if (state == DATA && tick) begin
        shreg <= shreg_in[DATA_W:1];
        idx   <= idx + IDX_W'(1);
      end
    end
  end

`ifdef WIRE_SERIAL_RX_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      par_bad <= 1'b0;
    else if (state == START)         par_bad <= 1'b0;
    else if (state == PARITY && tick) par_bad <= line_s ^ (^shreg);
  end
`else
  assign par_bad = 1'b0;
`endif

  // A full buffer that drains this cycle can still take the new word.
  assign load = word_ok && (!out_valid || out_ready);
  assign drop = word_ok && out_valid && !out_ready;

  // Output buffer and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= stop_bad;
      overrun    <= drop;
      parity_err <= par_fail;
      if (load) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wire_serial_rx.sv
// tb/tb_wire_serial_rx.sv - self-checking bench for wire_serial_rx
module tb_wire_serial_rx;

  localparam int DW  = 8;
  localparam int CPB = 16;
`ifdef WIRE_SERIAL_RX_PARITY_EN
  localparam int LAT = 170;
  localparam int PB  = 1;
`else
  localparam int LAT = 154;
  localparam int PB  = 0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    logic [DW-1:0] exp_data;
    int            exp_rise;
    int            exp_fe;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in = 1'b1;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  wire_serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int n_rise = 0;
  int n_vhigh = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_pe = 0;
  int rise_cyc = 0;
  logic [DW-1:0] rise_data = '0;
  logic prev_v = 1'b0;

  always @(posedge clk) begin
    #1;
    if (out_valid && !prev_v) begin
      n_rise++;
      rise_cyc = cyc;
      rise_data = out_data;
    end
    if (out_valid) n_vhigh++;
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (parity_err) n_pe++;
    prev_v = out_valid;
  end

  task automatic clr();
    n_rise = 0;
    n_vhigh = 0;
    n_fe = 0;
    n_ov = 0;
    n_pe = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drives one frame; t returns the first edge at which flop 1 sees the start bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int extra_low,
                            input logic bad_par, output int t);
    @(negedge clk);
    t = cyc + 1;
    in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      in = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef WIRE_SERIAL_RX_PARITY_EN
    in = bad_par ? ~(^d) : (^d);
    repeat (CPB) @(negedge clk);
`else
    if (bad_par) $display("note: parity bit not sent in this build");
`endif
    in = stop;
    repeat (CPB) @(negedge clk);
    repeat (extra_low) @(negedge clk);
    in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    vec_t vt[6];
    vt[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vt[1] = '{8'hC3, 1'b1, 8'hC3, 1, 0};
    vt[2] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vt[3] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vt[4] = '{8'h80, 1'b0, 8'h00, 0, 1};
    vt[5] = '{8'h01, 1'b1, 8'h01, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_out_valid", out_valid, 0);

    // Table-driven frames with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clr();
      send_frame(vt[i].data, vt[i].stop, 0, 1'b0, t);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_rise_cnt", i), n_rise, vt[i].exp_rise);
      chk($sformatf("v%0d_frame_err", i), n_fe, vt[i].exp_fe);
      chk($sformatf("v%0d_overrun", i), n_ov, 0);
      chk($sformatf("v%0d_parity_err", i), n_pe, 0);
      if (vt[i].exp_rise != 0) begin
        chk($sformatf("v%0d_latency", i), rise_cyc - t, LAT);
        chk($sformatf("v%0d_data", i), rise_data, vt[i].exp_data);
        chk($sformatf("v%0d_valid_cycles", i), n_vhigh, 1);
      end
    end

    // Short low glitch is rejected, following frame is received
    clr();
    @(negedge clk);
    in = 1'b0;
    repeat (4) @(negedge clk);
    in = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rise", n_rise, 0);
    chk("glitch_fe", n_fe, 0);
    send_frame(8'h3C, 1'b1, 0, 1'b0, t);
    chk("after_glitch_latency", rise_cyc - t, LAT);
    chk("after_glitch_data", rise_data, 8'h3C);

    // Stop bit 0 with line held low: one frame_err only
    clr();
    send_frame(8'h81, 1'b0, 40, 1'b0, t);
    repeat (20) @(negedge clk);
    chk("break_fe_count", n_fe, 1);
    chk("break_rise", n_rise, 0);
    send_frame(8'h01, 1'b1, 0, 1'b0, t);
    chk("after_break_data", rise_data, 8'h01);
    chk("after_break_latency", rise_cyc - t, LAT);
    chk("after_break_fe", n_fe, 1);

    // Overrun with out_ready=0
    clr();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0, 1'b0, t);
    chk("ovr_first_valid", out_valid, 1);
    chk("ovr_first_data", out_data, 8'h11);
    send_frame(8'h22, 1'b1, 0, 1'b0, t);
    chk("ovr_pulse_count", n_ov, 1);
    chk("ovr_kept_data", out_data, 8'h11);
    chk("ovr_rise_count", n_rise, 1);
    chk("ovr_still_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("ovr_drained_valid", out_valid, 0);

    // Reset during data bit 3 of 0xFF with a word buffered
    out_ready = 1'b0;
    send_frame(8'h33, 1'b1, 0, 1'b0, t);
    chk("pre_rst_valid", out_valid, 1);
    clr();
    @(negedge clk);
    in = 1'b0;
    repeat (CPB) @(negedge clk);
    in = 1'b1;
    repeat (3 * CPB + 8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_fe", frame_err, 0);
    chk("midrst_ovr", overrun, 0);
    chk("midrst_pe", parity_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8 + 4 * CPB + CPB + PB * CPB + 8) @(negedge clk);
    chk("post_rst_rise", n_rise, 0);
    chk("post_rst_fe", n_fe, 0);
    out_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 0, 1'b0, t);
    chk("post_rst_data", rise_data, 8'h5A);
    chk("post_rst_latency", rise_cyc - t, LAT);

`ifdef WIRE_SERIAL_RX_PARITY_EN
    clr();
    send_frame(8'h07, 1'b1, 0, 1'b0, t);
    chk("par_ok_latency", rise_cyc - t, 170);
    chk("par_ok_data", rise_data, 8'h07);
    chk("par_ok_pe", n_pe, 0);
    clr();
    send_frame(8'h07, 1'b1, 0, 1'b1, t);
    chk("par_bad_pe", n_pe, 1);
    chk("par_bad_rise", n_rise, 0);
    chk("par_bad_fe", n_fe, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wire_serial_rx.md
Name: wire_serial_rx

Overview:
- Receiving end of a single-wire serial link: samples one asynchronous bit line and reassembles framed words.
- Frame: idle-high line, one start bit (0), DATA_W data bits LSB first, one stop bit (1).
- Delivers each word through a one-entry valid/ready output buffer to downstream logic.
- Flags framing errors and overruns.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 16, clk cycles per bit period; minimum 4, must be even.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in  input  1  raw serial line, asynchronous to clk, idle high.
- out_data  output  DATA_W  received word, stable while out_valid=1.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts word when out_valid && out_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: word completed while buffer full and not draining.
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 unless PARITY_EN.

Behaviour:
- Reset (rst_n=0, async): synchronizer flops=1; state=IDLE; bit counter=0; out_data=0; out_valid=0; frame_err=0; overrun=0; parity_err=0.
- Synchronizer: 2 flops on in; FSM uses only the second flop output (line_s). Adds 2 cycles latency.
- IDLE: line_s=0 -> START, phase counter loaded with CLKS_PER_BIT/2-1.
- START: at counter 0, sample line_s:
  - 0 -> DATA, counter=CLKS_PER_BIT-1, bit index=0.
  - 1 -> IDLE (glitch rejected, no flags).
- DATA: sample line_s each time the counter reaches 0 and shift it into bit[index], LSB first. After bit DATA_W-1 -> STOP (or PARITY if enabled). Counter reloads to CLKS_PER_BIT-1.
- STOP: sample at counter 0.
  - 1 -> deliver word, go IDLE.
  - 0 -> frame_err pulse, word discarded, go BREAK.
- BREAK: wait until line_s=1, then IDLE. A held-low line produces only one frame_err.
- Deliver:
  - Buffer empty, or out_ready=1 the same cycle: load out_data, out_valid=1 next cycle. Simultaneous drain and load keeps out_valid=1 with the new word.
  - Buffer full and out_ready=0: new word dropped, old word kept, overrun pulses once.
- out_valid clears on the cycle after the handshake if no new word is loaded.
- Timing, CLKS_PER_BIT=16, DATA_W=8: let T be the first edge where in=0 is sampled by flop 1. Stop sample occurs at T+2+8+8*16+16 = T+154. out_valid=1 from T+155.
- Counter width is clog2(CLKS_PER_BIT). Bit index width is clog2(DATA_W+1).
- Reset mid-frame: all state is lost immediately and no partial word is delivered. After release, a line already low is treated as a start edge.

Optional Feature:
- Macro: WIRE_SERIAL_RX_PARITY_EN.
- Defined: a PARITY state after DATA samples one even-parity bit.
  - Mismatch -> parity_err pulse (same cycle the stop bit is evaluated), word discarded, stop bit still checked.
  - Frame is CLKS_PER_BIT longer; out_valid at T+171.
- Undefined: no PARITY state; parity_err tied to 0.

Test Plan:
1. CLKS_PER_BIT=16, out_ready=1, send 0xA5 -> out_valid high exactly at T+155, out_data=0xA5. No error pulses.
2. in low for 4 cycles then high -> no out_valid, no flags. A following frame 0x3C is received as 0x3C.
3. Frame 0x81 with stop bit 0, line held low 40 cycles then high -> exactly one frame_err pulse, out_valid stays 0. Next frame 0x01 is received correctly.
4. out_ready=0, send 0x11 then 0x22 -> out_data=0x11, one overrun pulse at the second stop sample. Raising out_ready consumes 0x11 and out_valid then falls.
5. rst_n pulsed low during data bit 3 of 0xFF -> all outputs 0 immediately, no word delivered. After release, frame 0x5A is received as 0x5A.
6. PARITY_EN defined:
   - 0x07 with parity bit 1 -> delivered at T+171.
   - 0x07 with parity bit 0 -> parity_err pulse, no out_valid.
